// File: rtl/dht11_uart_reporter_pkg.sv
// rtl/dht11_uart_reporter_pkg.sv - shared ASCII constants, FSM codes and measurement record
package dht11_uart_reporter_pkg;

  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_R     = 8'h52;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONV  = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_ACK_H = 3'd3;
  localparam logic [2:0] ST_ACK_L = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  typedef struct packed {
    logic [7:0] hum;
    logic [7:0] temp;
    logic       valid;
  } meas_t;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASC_0 | {4'h0, d};
  endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// rtl/bin8_to_bcd.sv - double-dabble 8-bit binary to three BCD digits, one load + 8 shift cycles
module bin8_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] sr;
  logic [2:0]  cnt;
  logic [11:0] adj;

  // Add-3 correction on every digit that would overflow once doubled.
  always_comb begin
    adj = sr[19:8];
    for (int k = 0; k < 3; k++) begin
      if (sr[8+4*k +: 4] >= 4'd5) adj[4*k +: 4] = sr[8+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sr   <= {12'd0, bin};
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        sr  <= {adj[10:0], sr[7:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr[19:8];

endmodule

// File: rtl/dht11_uart_reporter.sv
// rtl/dht11_uart_reporter.sv - formats each DHT11 measurement as an ASCII line and streams it to the UART TX
module dht11_uart_reporter
  import dht11_uart_reporter_pkg::*;
#(
  parameter int BUSY_TO  = 16,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dht_humidity,
  input  logic [15:0] dht_temperature,
  input  logic        dht_done,
  input  logic        dht_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        rpt_busy,
  output logic        rpt_done,
  output logic [7:0]  drop_cnt
);

  localparam logic [3:0] LAST_IDX = EOL_CRLF ? 4'd12 : 4'd11;
  localparam logic [7:0] TO_LAST  = 8'(BUSY_TO - 1);

  logic        done_d;
  meas_t       shadow, frame;
  logic [2:0]  state;
  logic [4:0]  conv_cnt;
  logic [3:0]  idx;
  logic [7:0]  to_cnt;
  logic [11:0] hum_bcd;
  logic [11:0] temp_bcd;
  logic        bcd_start, bcd_busy, bcd_done;
  logic [7:0]  byte_sel;
  logic        byte_done;
  logic        unused_lo;

  wire trigger = done_d & ~dht_done;

  assign unused_lo = ^{dht_humidity[7:0], dht_temperature[7:0]};

  // Humidity converts first, temperature right after; the second result stays on bcd output.
  assign bcd_start = (state == ST_CONV) && ((conv_cnt == 5'd0) || (conv_cnt == 5'd9)) && !bcd_busy;

  bin8_to_bcd u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   ((conv_cnt < 5'd9) ? frame.hum : frame.temp),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (temp_bcd)
  );

  assign byte_done = ((state == ST_ACK_H) && !tx_busy && (to_cnt == TO_LAST)) ||
                     ((state == ST_ACK_L) && !tx_busy);

  always_comb begin
    byte_sel = ASC_LF;
    case (idx)
      4'd0:    byte_sel = ASC_H;
      4'd1:    byte_sel = ASC_COLON;
      4'd2:    byte_sel = frame.valid ? digit_ascii(hum_bcd[11:8])  : ASC_E;
      4'd3:    byte_sel = frame.valid ? digit_ascii(hum_bcd[7:4])   : ASC_R;
      4'd4:    byte_sel = frame.valid ? digit_ascii(hum_bcd[3:0])   : ASC_R;
      4'd5:    byte_sel = ASC_SPACE;
      4'd6:    byte_sel = ASC_T;
      4'd7:    byte_sel = ASC_COLON;
      4'd8:    byte_sel = frame.valid ? digit_ascii(temp_bcd[11:8]) : ASC_E;
      4'd9:    byte_sel = frame.valid ? digit_ascii(temp_bcd[7:4])  : ASC_R;
      4'd10:   byte_sel = frame.valid ? digit_ascii(temp_bcd[3:0])  : ASC_R;
      4'd11:   byte_sel = EOL_CRLF ? ASC_CR : ASC_LF;
      default: byte_sel = ASC_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d   <= 1'b0;
      shadow   <= '0;
      frame    <= '0;
      state    <= ST_IDLE;
      conv_cnt <= '0;
      idx      <= '0;
      to_cnt   <= '0;
      hum_bcd  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      rpt_busy <= 1'b0;
      rpt_done <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done_d   <= dht_done;
      tx_start <= 1'b0;
      rpt_done <= 1'b0;
      if (dht_done) shadow <= {dht_humidity[15:8], dht_temperature[15:8], dht_valid};
      if (trigger && rpt_busy && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      if (byte_done) begin
        if (idx == LAST_IDX) begin
          state <= ST_FIN;
        end else begin
          idx   <= idx + 4'd1;
          state <= ST_SEND;
        end
      end

      case (state)
        ST_IDLE: if (trigger) begin
          frame    <= shadow;
          rpt_busy <= 1'b1;
          conv_cnt <= '0;
          state    <= ST_CONV;
        end
        ST_CONV: begin
          conv_cnt <= conv_cnt + 5'd1;
          if (bcd_done && (conv_cnt == 5'd9)) hum_bcd <= temp_bcd;
          if (conv_cnt == 5'd17) state <= ST_SEND;
        end
        ST_SEND: if (!tx_busy) begin
          tx_data  <= byte_sel;
          tx_start <= 1'b1;
          to_cnt   <= '0;
          state    <= ST_ACK_H;
        end
        ST_ACK_H: begin
          if (tx_busy) state <= ST_ACK_L;
          else if (!byte_done) to_cnt <= to_cnt + 8'd1;
        end
        ST_ACK_L: ;
        ST_FIN: begin
          rpt_done <= 1'b1;
          rpt_busy <= 1'b0;
          idx      <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// tb/tb_dht11_uart_reporter.sv - randomized bench with UART TX model and string-level line reference
module tb_dht11_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] hum = '0, temp = '0;
  logic        done = 1'b0, valid = 1'b0;
  logic        hold = 1'b0, mute = 1'b0;
  logic        tx_busy0, tx_busy1;
  logic [7:0]  txd0, txd1, dc0, dc1;
  logic        st0, st1, rb0, rb1, rd0, rd1;

  dht11_uart_reporter u_dut (
    .clk(clk), .rst_n(rst_n), .dht_humidity(hum), .dht_temperature(temp),
    .dht_done(done), .dht_valid(valid), .tx_busy(tx_busy0), .tx_data(txd0),
    .tx_start(st0), .rpt_busy(rb0), .rpt_done(rd0), .drop_cnt(dc0)
  );

  dht11_uart_reporter #(.EOL_CRLF(1'b0)) u_dut_lf (
    .clk(clk), .rst_n(rst_n), .dht_humidity(hum), .dht_temperature(temp),
    .dht_done(done), .dht_valid(valid), .tx_busy(tx_busy1), .tx_data(txd1),
    .tx_start(st1), .rpt_busy(rb1), .rpt_done(rd1), .drop_cnt(dc1)
  );

  // UART model: busy rises one cycle after tx_start is seen and stays high 10 cycles.
  logic       pend0 = 1'b0, pend1 = 1'b0, mbusy0 = 1'b0, mbusy1 = 1'b0;
  logic [3:0] bcnt0 = '0, bcnt1 = '0;
  assign tx_busy0 = mbusy0 | hold;
  assign tx_busy1 = mbusy1 | hold;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend0 <= 1'b0; pend1 <= 1'b0; mbusy0 <= 1'b0; mbusy1 <= 1'b0; bcnt0 <= '0; bcnt1 <= '0;
    end else begin
      pend0 <= st0 && !mute;
      pend1 <= st1 && !mute;
      if (pend0) begin mbusy0 <= 1'b1; bcnt0 <= 4'd10; end
      else if (bcnt0 != 0) begin bcnt0 <= bcnt0 - 4'd1; if (bcnt0 == 4'd1) mbusy0 <= 1'b0; end
      if (pend1) begin mbusy1 <= 1'b1; bcnt1 <= 4'd10; end
      else if (bcnt1 != 0) begin bcnt1 <= bcnt1 - 4'd1; if (bcnt1 == 4'd1) mbusy1 <= 1'b0; end
    end
  end

  logic [7:0] q0[$], q1[$];
  int         t0[$];
  int         ncyc = 0, fall_n = 0, rd_cnt0 = 0, rd_cnt1 = 0, viol = 0;
  logic       prev_done = 1'b0, prev_st0 = 1'b0, prev_st1 = 1'b0;

  always @(negedge clk) begin
    ncyc      <= ncyc + 1;
    prev_done <= done;
    prev_st0  <= st0;
    prev_st1  <= st1;
    if (prev_done && !done) fall_n <= ncyc;
    if (st0) begin q0.push_back(txd0); t0.push_back(ncyc); end
    if (st1) q1.push_back(txd1);
    if (rd0) rd_cnt0 <= rd_cnt0 + 1;
    if (rd1) rd_cnt1 <= rd_cnt1 + 1;
    viol <= viol + int'(st0 && (tx_busy0 || prev_st0)) + int'(st1 && (tx_busy1 || prev_st1));
  end

  int checks = 0, failures = 0;
  int base0 = 0, base1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: the report line as text, then terminated per line-ending mode.
  task automatic check_frame(input string tag, input logic [7:0] got[$],
                             input int h, input int t, input bit v, input bit crlf);
    string      s;
    logic [7:0] e[$];
    s = v ? $sformatf("H:%03d T:%03d", h, t) : "H:ERR T:ERR";
    for (int i = 0; i < s.len(); i++) e.push_back(s[i]);
    if (crlf) e.push_back(8'h0D);
    e.push_back(8'h0A);
    check({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, e[i]});
  endtask

  task automatic pulse(input logic [7:0] h, input logic [7:0] t, input bit v, input int len);
    hum   = {h, 8'($urandom)};
    temp  = {t, 8'($urandom)};
    valid = v;
    done  = 1'b1;
    tick(len);
    done  = 1'b0;
    hum   = 16'($urandom);
    temp  = 16'($urandom);
    valid = 1'($urandom);
  endtask

  task automatic start_mon();
    q0.delete(); q1.delete(); t0.delete();
    base0 = rd_cnt0;
    base1 = rd_cnt1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((rd_cnt0 == base0 || rd_cnt1 == base1) && k < 5000) begin tick(); k++; end
    check({tag, "_timeout"}, k < 5000, 1);
    tick(2);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (q0.size() < n && k < 2000) begin tick(); k++; end
    check({tag, "_byte_wait"}, k < 2000, 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] h, input logic [7:0] t,
                           input bit v, input int exp_drop);
    start_mon();
    pulse(h, t, v, 50);
    wait_idle(tag);
    check({tag, "_latency"}, (t0.size() > 0) ? t0[0] - fall_n : -1, 20);
    check_frame({tag, "_crlf"}, q0, h, t, v, 1'b1);
    check_frame({tag, "_lf"}, q1, h, t, v, 1'b0);
    check({tag, "_rpt_done0"}, rd_cnt0 - base0, 1);
    check({tag, "_rpt_done1"}, rd_cnt1 - base1, 1);
    check({tag, "_drop"}, dc0, exp_drop);
  endtask

  initial begin
    int k;
    tick(3);
    check("rst_tx_start", st0, 0);
    check("rst_tx_data", txd0, 0);
    check("rst_rpt_busy", rb0, 0);
    check("rst_rpt_done", rd0, 0);
    check("rst_drop_cnt", dc0, 0);
    rst_n = 1'b1;
    tick(5);

    run_frame("valid_45_23", 8'h2D, 8'h17, 1'b1, 0);
    run_frame("invalid", 8'h2D, 8'h17, 1'b0, 0);
    run_frame("max_min", 8'hFF, 8'h00, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);

    start_mon();
    pulse(8'd61, 8'd199, 1'b1, 50);
    wait_bytes("drop", 5);
    pulse(8'd7, 8'd8, 1'b0, 3);
    tick();
    check("drop_one", dc0, 1);
    k = 0;
    while ((st0 || st1) && k < 10) begin tick(); k++; end
    hold = 1'b1;
    for (int i = 0; i < 300; i++) begin
      done = 1'b1; hum = 16'($urandom); tick();
      done = 1'b0; tick();
    end
    tick(2);
    check("drop_sat0", dc0, 255);
    check("drop_sat1", dc1, 255);
    check("drop_still_busy", rb0, 1);
    hold = 1'b0;
    wait_idle("drop");
    check_frame("drop_frame_crlf", q0, 61, 199, 1'b1, 1'b1);
    check_frame("drop_frame_lf", q1, 61, 199, 1'b1, 1'b0);
    check("drop_rpt_done", rd_cnt0 - base0, 1);

    mute = 1'b1;
    run_frame("timeout", 8'd100, 8'd9, 1'b1, 255);
    k = 0;
    for (int i = 1; i < t0.size(); i++) if (t0[i] - t0[i-1] > k) k = t0[i] - t0[i-1];
    check("timeout_gap", k, 17);
    mute = 1'b0;

    start_mon();
    pulse(8'd12, 8'd34, 1'b1, 50);
    wait_bytes("reset", 7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", st0, 0);
    check("mid_rst_rpt_busy", rb0, 0);
    check("mid_rst_drop_cnt", dc0, 0);
    check("mid_rst_tx_data", txd0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    run_frame("after_rst", 8'($urandom), 8'($urandom), 1'b1, 0);

    check("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
